// File: rtl/pwm_fault_guard_if.sv
// pwm_fault_guard_if: gate, fault and control signals of the PWM fault guard
// master: drives gate inputs, fault input and configuration; observes protected gates and flags
// slave:  the guard itself
interface pwm_fault_guard_if #(
   parameter int FILT_W  = 8,
   parameter int RECOV_W = 16
);
   logic               guard_en;
   logic               pwm_h_in;
   logic               pwm_l_in;
   logic               fault_in;
   logic [FILT_W-1:0]  filt_len;
   logic               auto_recover;
   logic [RECOV_W-1:0] recov_len;
   logic               fault_clr;
   logic               safe_h;
   logic               safe_l;
   logic               pwm_h_out;
   logic               pwm_l_out;
   logic               fault_active;
   logic               fault_flag;
   logic               st_flag;
   modport master (
      output guard_en, pwm_h_in, pwm_l_in, fault_in, filt_len, auto_recover,
             recov_len, fault_clr, safe_h, safe_l,
      input  pwm_h_out, pwm_l_out, fault_active, fault_flag, st_flag
   );
   modport slave (
      input  guard_en, pwm_h_in, pwm_l_in, fault_in, filt_len, auto_recover,
             recov_len, fault_clr, safe_h, safe_l,
      output pwm_h_out, pwm_l_out, fault_active, fault_flag, st_flag
   );
endinterface

// File: rtl/pwm_fault_guard.sv
// pwm_fault_guard: forces the gate pair to safe levels on external fault or shoot-through
// clk, rst       : clock, asynchronous active-high reset
// bus (slave)    : gate inputs/outputs, fault input, filter/recovery config, status flags
module pwm_fault_guard #(
   parameter int FILT_W  = 8,
   parameter int RECOV_W = 16
) (
   input logic              clk,
   input logic              rst,
   pwm_fault_guard_if.slave bus
);
   localparam logic [1:0] RUN     = 2'd0;
   localparam logic [1:0] FAULT   = 2'd1;
   localparam logic [1:0] RECOVER = 2'd2;
   logic               s1, fs;
   logic [FILT_W-1:0]  cnt;
   logic [RECOV_W-1:0] tmr;
   logic [1:0]         state, state_n;
   logic               confirm, st, st_set, flt_set;
   always_comb begin
      confirm = fs & (cnt >= bus.filt_len);
      st      = bus.pwm_h_in & bus.pwm_l_in;
      state_n = RUN;
      case (state)
         RUN:     state_n = (confirm | st) ? FAULT : RUN;
         FAULT:   state_n = (!fs && (bus.auto_recover || bus.fault_clr)) ? RECOVER : FAULT;
         RECOVER: state_n = (confirm | st) ? FAULT :
                            (tmr >= bus.recov_len && !bus.pwm_h_in && !bus.pwm_l_in) ? RUN : RECOVER;
         default: state_n = RUN;
      endcase
      if (!bus.guard_en) state_n = RUN;
      // shoot-through is only meaningful while the gates are actually forwarded or re-arming
      st_set  = bus.guard_en & st & (state != FAULT);
      flt_set = bus.guard_en & confirm;
   end
   assign bus.fault_active = (state != RUN);
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1             <= 1'b0;
         fs             <= 1'b0;
         cnt            <= '0;
         tmr            <= '0;
         state          <= RUN;
         bus.pwm_h_out  <= 1'b0;
         bus.pwm_l_out  <= 1'b0;
         bus.fault_flag <= 1'b0;
         bus.st_flag    <= 1'b0;
      end else begin
         s1             <= bus.fault_in;
         fs             <= s1;
         cnt            <= fs ? ((&cnt) ? cnt : cnt + 1'b1) : '0;
         // timer is held at zero in FAULT so RECOVER always starts counting from zero
         tmr            <= (state == FAULT) ? '0 :
                           (state == RECOVER && !fs && !(&tmr)) ? tmr + 1'b1 : tmr;
         state          <= state_n;
         bus.pwm_h_out  <= (state_n == RUN) ? bus.pwm_h_in : bus.safe_h;
         bus.pwm_l_out  <= (state_n == RUN) ? bus.pwm_l_in : bus.safe_l;
         bus.fault_flag <= flt_set ? 1'b1 : bus.fault_clr ? 1'b0 : bus.fault_flag;
         bus.st_flag    <= st_set  ? 1'b1 : bus.fault_clr ? 1'b0 : bus.st_flag;
      end
   end
endmodule

// File: tb/tb_pwm_fault_guard.sv
// tb_pwm_fault_guard: directed scenario checks of the PWM fault guard
module tb_pwm_fault_guard;
   logic clk, rst;
   int   tests = 0;
   int   fails = 0;
   pwm_fault_guard_if bus ();
   pwm_fault_guard dut (.clk(clk), .rst(rst), .bus(bus));
   initial clk = 1'b0;
   always #5 clk = ~clk;
   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask
   task automatic clr_pulse();
      bus.fault_clr = 1'b1;
      step(1);
      bus.fault_clr = 1'b0;
   endtask
   task automatic to_run();
      bus.fault_in = 1'b0;
      bus.auto_recover = 1'b1;
      bus.recov_len = '0;
      bus.pwm_h_in = 1'b0;
      bus.pwm_l_in = 1'b0;
      step(6);
      clr_pulse();
      step(2);
   endtask
   task automatic test_reset();
      rst = 1'b1;
      bus.guard_en = 1'b1;
      bus.pwm_h_in = 1'b0;
      bus.pwm_l_in = 1'b0;
      bus.fault_in = 1'b0;
      bus.filt_len = 8'd4;
      bus.auto_recover = 1'b0;
      bus.recov_len = 16'd10;
      bus.fault_clr = 1'b0;
      bus.safe_h = 1'b0;
      bus.safe_l = 1'b1;
      step(3);
      tests++;
      if ({bus.pwm_h_out, bus.pwm_l_out, bus.fault_active, bus.fault_flag, bus.st_flag} !== 5'b0) begin
         fails++;
         $display("FAIL reset got=%b%b%b%b%b exp=00000", bus.pwm_h_out, bus.pwm_l_out,
                  bus.fault_active, bus.fault_flag, bus.st_flag);
      end
      rst = 1'b0;
      step(1);
   endtask
   task automatic test_passthrough();
      logic [1:0] pat [3] = '{2'b10, 2'b01, 2'b00};
      for (int i = 0; i < 3; i++) begin
         {bus.pwm_h_in, bus.pwm_l_in} = pat[i];
         step(1);
         tests++;
         if ({bus.pwm_h_out, bus.pwm_l_out} !== pat[i]) begin
            fails++;
            $display("FAIL passthrough_%0d got=%b%b exp=%b", i, bus.pwm_h_out, bus.pwm_l_out, pat[i]);
         end
      end
   endtask
   task automatic test_glitch_filter();
      bus.pwm_h_in = 1'b1;
      bus.pwm_l_in = 1'b0;
      bus.fault_in = 1'b1;
      step(3);
      bus.fault_in = 1'b0;
      step(6);
      tests++;
      if (bus.fault_active !== 1'b0 || bus.fault_flag !== 1'b0 || {bus.pwm_h_out, bus.pwm_l_out} !== 2'b10) begin
         fails++;
         $display("FAIL glitch active=%b flag=%b out=%b%b exp active=0 flag=0 out=10",
                  bus.fault_active, bus.fault_flag, bus.pwm_h_out, bus.pwm_l_out);
      end
   endtask
   task automatic test_confirm_and_manual_clear();
      bus.auto_recover = 1'b0;
      bus.recov_len = '0;
      bus.fault_in = 1'b1;
      step(6);
      tests++;
      if (bus.fault_active !== 1'b0 || {bus.pwm_h_out, bus.pwm_l_out} !== 2'b10) begin
         fails++;
         $display("FAIL confirm_edge6 active=%b out=%b%b exp active=0 out=10",
                  bus.fault_active, bus.pwm_h_out, bus.pwm_l_out);
      end
      step(1);
      tests++;
      if (bus.fault_active !== 1'b1 || bus.fault_flag !== 1'b1 || {bus.pwm_h_out, bus.pwm_l_out} !== 2'b01) begin
         fails++;
         $display("FAIL confirm_edge7 active=%b flag=%b out=%b%b exp active=1 flag=1 out=01",
                  bus.fault_active, bus.fault_flag, bus.pwm_h_out, bus.pwm_l_out);
      end
      bus.fault_in = 1'b0;
      step(5);
      tests++;
      if (bus.fault_active !== 1'b1 || bus.fault_flag !== 1'b1) begin
         fails++;
         $display("FAIL hold_fault active=%b flag=%b exp active=1 flag=1", bus.fault_active, bus.fault_flag);
      end
      clr_pulse();
      tests++;
      if (bus.fault_active !== 1'b1 || bus.fault_flag !== 1'b0) begin
         fails++;
         $display("FAIL manual_clr active=%b flag=%b exp active=1 flag=0", bus.fault_active, bus.fault_flag);
      end
      step(3);
      tests++;
      if (bus.fault_active !== 1'b1 || {bus.pwm_h_out, bus.pwm_l_out} !== 2'b01) begin
         fails++;
         $display("FAIL wait_gap active=%b out=%b%b exp active=1 out=01",
                  bus.fault_active, bus.pwm_h_out, bus.pwm_l_out);
      end
      bus.pwm_h_in = 1'b0;
      step(1);
      tests++;
      if (bus.fault_active !== 1'b0 || {bus.pwm_h_out, bus.pwm_l_out} !== 2'b00) begin
         fails++;
         $display("FAIL gap_reentry active=%b out=%b%b exp active=0 out=00",
                  bus.fault_active, bus.pwm_h_out, bus.pwm_l_out);
      end
      bus.pwm_h_in = 1'b1;
      step(1);
      tests++;
      if ({bus.pwm_h_out, bus.pwm_l_out} !== 2'b10) begin
         fails++;
         $display("FAIL after_reentry out=%b%b exp=10", bus.pwm_h_out, bus.pwm_l_out);
      end
   endtask
   task automatic test_set_wins();
      bus.filt_len = '0;
      bus.fault_in = 1'b1;
      step(2);
      tests++;
      if (bus.fault_active !== 1'b0) begin
         fails++;
         $display("FAIL filt0_edge2 active=%b exp=0", bus.fault_active);
      end
      clr_pulse();
      tests++;
      if (bus.fault_active !== 1'b1 || bus.fault_flag !== 1'b1 || {bus.pwm_h_out, bus.pwm_l_out} !== 2'b01) begin
         fails++;
         $display("FAIL set_wins active=%b flag=%b out=%b%b exp active=1 flag=1 out=01",
                  bus.fault_active, bus.fault_flag, bus.pwm_h_out, bus.pwm_l_out);
      end
      clr_pulse();
      tests++;
      if (bus.fault_active !== 1'b1 || bus.fault_flag !== 1'b1) begin
         fails++;
         $display("FAIL clr_while_fs active=%b flag=%b exp active=1 flag=1", bus.fault_active, bus.fault_flag);
      end
      to_run();
      bus.filt_len = 8'd4;
      bus.pwm_h_in = 1'b1;
      step(1);
   endtask
   task automatic test_auto_recover();
      bus.auto_recover = 1'b1;
      bus.recov_len = 16'd10;
      bus.fault_in = 1'b1;
      step(7);
      bus.fault_in = 1'b0;
      bus.pwm_h_in = 1'b0;
      step(13);
      tests++;
      if (bus.fault_active !== 1'b1 || {bus.pwm_h_out, bus.pwm_l_out} !== 2'b01) begin
         fails++;
         $display("FAIL auto_edge20 active=%b out=%b%b exp active=1 out=01",
                  bus.fault_active, bus.pwm_h_out, bus.pwm_l_out);
      end
      step(1);
      tests++;
      if (bus.fault_active !== 1'b0 || bus.fault_flag !== 1'b1 || {bus.pwm_h_out, bus.pwm_l_out} !== 2'b00) begin
         fails++;
         $display("FAIL auto_edge21 active=%b flag=%b out=%b%b exp active=0 flag=1 out=00",
                  bus.fault_active, bus.fault_flag, bus.pwm_h_out, bus.pwm_l_out);
      end
      bus.pwm_l_in = 1'b1;
      step(1);
      tests++;
      if ({bus.pwm_h_out, bus.pwm_l_out} !== 2'b01 || bus.fault_active !== 1'b0) begin
         fails++;
         $display("FAIL auto_follow out=%b%b active=%b exp out=01 active=0",
                  bus.pwm_h_out, bus.pwm_l_out, bus.fault_active);
      end
   endtask
   task automatic test_shoot_through_and_reset();
      bus.pwm_h_in = 1'b1;
      bus.pwm_l_in = 1'b0;
      clr_pulse();
      bus.recov_len = 16'd3;
      bus.pwm_l_in = 1'b1;
      step(1);
      bus.pwm_l_in = 1'b0;
      tests++;
      if (bus.fault_active !== 1'b1 || bus.st_flag !== 1'b1 || bus.fault_flag !== 1'b0 ||
          {bus.pwm_h_out, bus.pwm_l_out} !== 2'b01) begin
         fails++;
         $display("FAIL st_run active=%b st=%b flt=%b out=%b%b exp active=1 st=1 flt=0 out=01",
                  bus.fault_active, bus.st_flag, bus.fault_flag, bus.pwm_h_out, bus.pwm_l_out);
      end
      step(1);
      bus.auto_recover = 1'b0;
      step(1);
      bus.pwm_l_in = 1'b1;
      step(1);
      bus.pwm_h_in = 1'b0;
      bus.pwm_l_in = 1'b0;
      step(8);
      tests++;
      if (bus.fault_active !== 1'b1 || {bus.pwm_h_out, bus.pwm_l_out} !== 2'b01) begin
         fails++;
         $display("FAIL st_recover active=%b out=%b%b exp active=1 out=01",
                  bus.fault_active, bus.pwm_h_out, bus.pwm_l_out);
      end
      bus.pwm_h_in = 1'b1;
      clr_pulse();
      step(2);
      tests++;
      if (bus.fault_active !== 1'b1 || bus.pwm_l_out !== 1'b1 || bus.st_flag !== 1'b0) begin
         fails++;
         $display("FAIL pre_rst active=%b l_out=%b st=%b exp active=1 l_out=1 st=0",
                  bus.fault_active, bus.pwm_l_out, bus.st_flag);
      end
      bus.pwm_l_in = 1'b1;
      step(1);
      bus.pwm_l_in = 1'b0;
      #2 rst = 1'b1;
      #1;
      tests++;
      if ({bus.pwm_h_out, bus.pwm_l_out, bus.fault_active, bus.st_flag} !== 4'b0) begin
         fails++;
         $display("FAIL async_rst out=%b%b active=%b st=%b exp all 0",
                  bus.pwm_h_out, bus.pwm_l_out, bus.fault_active, bus.st_flag);
      end
      step(1);
      rst = 1'b0;
      step(1);
      tests++;
      if (bus.fault_active !== 1'b0 || bus.st_flag !== 1'b0 || bus.fault_flag !== 1'b0 ||
          {bus.pwm_h_out, bus.pwm_l_out} !== 2'b10) begin
         fails++;
         $display("FAIL post_rst active=%b st=%b flt=%b out=%b%b exp active=0 st=0 flt=0 out=10",
                  bus.fault_active, bus.st_flag, bus.fault_flag, bus.pwm_h_out, bus.pwm_l_out);
      end
   endtask
   task automatic test_bypass();
      bus.filt_len = 8'd2;
      bus.guard_en = 1'b0;
      bus.pwm_l_in = 1'b1;
      bus.fault_in = 1'b1;
      step(1);
      tests++;
      if ({bus.pwm_h_out, bus.pwm_l_out} !== 2'b11 || bus.fault_active !== 1'b0) begin
         fails++;
         $display("FAIL bypass_out out=%b%b active=%b exp out=11 active=0",
                  bus.pwm_h_out, bus.pwm_l_out, bus.fault_active);
      end
      step(8);
      tests++;
      if (bus.fault_active !== 1'b0 || bus.st_flag !== 1'b0 || bus.fault_flag !== 1'b0) begin
         fails++;
         $display("FAIL bypass_flags active=%b st=%b flt=%b exp all 0",
                  bus.fault_active, bus.st_flag, bus.fault_flag);
      end
      bus.pwm_l_in = 1'b0;
      bus.guard_en = 1'b1;
      step(1);
      tests++;
      if (bus.fault_active !== 1'b1 || bus.fault_flag !== 1'b1 || bus.st_flag !== 1'b0 ||
          {bus.pwm_h_out, bus.pwm_l_out} !== 2'b01) begin
         fails++;
         $display("FAIL reenable active=%b flt=%b st=%b out=%b%b exp active=1 flt=1 st=0 out=01",
                  bus.fault_active, bus.fault_flag, bus.st_flag, bus.pwm_h_out, bus.pwm_l_out);
      end
   endtask
   initial begin
      test_reset();
      test_passthrough();
      test_glitch_filter();
      test_confirm_and_manual_clear();
      test_set_wins();
      test_auto_recover();
      test_shoot_through_and_reset();
      test_bypass();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
